bcd_seg_counter: RTL and testbench

Parametrised multi-digit BCD counter with synchronous load, up/down counting and a built-in multiplexed seven-segment scan driver. It generalises the single-digit BCD load/display block to DIGITS decimal digits, adds a count direction, enable and terminal-count output, and time-multiplexes the digits onto one shared segment bus. It sits between front-panel or control logic, which supplies the load value and count enables, and the board's seven-segment display.

---
 rtl/bcd_seg_counter.sv | 136 +++++++++++++
 tb/tb_bcd_seg_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_counter.sv
// Multi-digit BCD up/down counter with synchronous clamped load, terminal-count
// pulse and a registered, time-multiplexed seven-segment scan driver.
module bcd_seg_counter #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 4,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic                  load_syn,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic                  en,
    input  logic                  up_dn,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
    localparam logic        INV       = (COMMON_ANODE != 0);

    function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            default: return 7'h6F;
        endcase
    endfunction

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                tc_q, tc_d;
    logic [15:0]         scan_cnt_q, scan_cnt_d;
    logic                scan_wrap;
    logic [IDX_W-1:0]    digit_idx_q;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          nib;
    logic [3:0]          sel_digit;
    logic                carry;

    // carry survives the whole ripple only when every digit rolled over: that is the wrap
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        carry   = 1'b1;
        nib     = 4'd0;
        if (load_syn) begin
            for (int k = 0; k < DIGITS; k++)
                count_d[4*k +: 4] = clamp_bcd(Din[4*k +: 4]);
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                nib = count_q[4*k +: 4];
                if (carry) begin
                    if (up_dn) begin
                        if (nib == 4'd9) begin
                            count_d[4*k +: 4] = 4'd0;
                        end else begin
                            count_d[4*k +: 4] = nib + 4'd1;
                            carry             = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            count_d[4*k +: 4] = 4'd9;
                        end else begin
                            count_d[4*k +: 4] = nib - 4'd1;
                            carry             = 1'b0;
                        end
                    end
                end
            end
            tc_d = carry;
        end
    end

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
        sel_digit  = count_q[{digit_idx_q, 2'b00} +: 4];
        seg_d      = seg_enc(sel_digit) ^ {7{INV}};
        an_d       = (DIGITS'(1) << digit_idx_q) ^ {DIGITS{INV}};
    end

    generate
        if (DIGITS > 1) begin : g_idx
            logic [IDX_W-1:0] digit_idx_d;

            always_comb begin
                digit_idx_d = digit_idx_q;
                if (scan_wrap)
                    digit_idx_d = (digit_idx_q == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
            end

            always_ff @(posedge clk or negedge rst_syn) begin
                if (!rst_syn) digit_idx_q <= '0;
                else          digit_idx_q <= digit_idx_d;
            end
        end else begin : g_no_idx
            assign digit_idx_q = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            scan_cnt_q <= 16'd0;
            seg_q      <= 7'h3F ^ {7{INV}};
            an_q       <= DIGITS'(1) ^ {DIGITS{INV}};
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            scan_cnt_q <= scan_cnt_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Randomized bench for bcd_seg_counter: two instances (common cathode and common
// anode) against a decimal-arithmetic reference model of count, tc and scan.
module tb_bcd_seg_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int MODULUS  = 10000;

    logic        clk;
    logic        rst_syn;
    logic        load_syn;
    logic [15:0] Din;
    logic        en;
    logic        up_dn;
    logic [15:0] count0, count1;
    logic        tc0, tc1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  an0, an1;

    bcd_seg_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .COMMON_ANODE(0)) u_cc (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .Din(Din), .en(en),
        .up_dn(up_dn), .count(count0), .tc(tc0), .seg(seg0), .an(an0)
    );

    bcd_seg_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .COMMON_ANODE(1)) u_ca (
        .clk(clk), .rst_syn(rst_syn), .load_syn(load_syn), .Din(Din), .en(en),
        .up_dn(up_dn), .count(count1), .tc(tc1), .seg(seg1), .an(an1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count held as a plain decimal integer
    int m_val;
    bit m_tc;
    int m_cyc;
    int disp_idx;
    int disp_val;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int load_value(input logic [15:0] d);
        int v = 0;
        for (int k = 0; k < DIGITS; k++) begin
            int n = int'((d >> (4*k)) & 16'hF);
            if (n > 9) n = 9;
            v += n * pow10(k);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int k = 0; k < DIGITS; k++)
            r |= 16'((v / pow10(k)) % 10) << (4*k);
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_tc = 0; m_cyc = 0; disp_idx = 0; disp_val = 0;
    endtask

    task automatic model_step(input logic ld, input logic [15:0] d, input logic e, input logic u);
        disp_idx = (m_cyc / SCAN_DIV) % DIGITS;
        disp_val = m_val;
        if (ld) begin
            m_val = load_value(d);
            m_tc  = 0;
        end else if (e) begin
            if (u) begin
                m_tc  = (m_val == MODULUS - 1);
                m_val = (m_val + 1) % MODULUS;
            end else begin
                m_tc  = (m_val == 0);
                m_val = (m_val + MODULUS - 1) % MODULUS;
            end
        end else begin
            m_tc = 0;
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [6:0] es;
        logic [3:0] ea;
        es = seg_tbl[(disp_val / pow10(disp_idx)) % 10];
        ea = 4'(1 << disp_idx);
        chk("count",    32'(count0), 32'(to_bcd(m_val)));
        chk("tc",       32'(tc0),    32'(m_tc));
        chk("seg",      32'(seg0),   32'(es));
        chk("an",       32'(an0),    32'(ea));
        chk("count_ca", 32'(count1), 32'(to_bcd(m_val)));
        chk("tc_ca",    32'(tc1),    32'(m_tc));
        chk("seg_ca",   32'(seg1),   32'(~es & 7'h7F));
        chk("an_ca",    32'(an1),    32'(~ea & 4'hF));
    endtask

    task automatic cycle(input logic ld, input logic [15:0] d, input logic e, input logic u);
        load_syn = ld; Din = d; en = e; up_dn = u;
        @(posedge clk);
        model_step(ld, d, e, u);
        #2;
        compare_all();
    endtask

    task automatic do_reset();
        rst_syn = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #2;
        compare_all();
        rst_syn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 200000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_syn = 1'b1; load_syn = 1'b0; Din = '0; en = 1'b0; up_dn = 1'b1;
        model_reset();
        #3;
        do_reset();

        // load with clamp, en also high: load wins
        cycle(1, 16'h59C5, 1, 1);
        chk("load_clamp", 32'(count0), 32'h5995);
        chk("load_tc", 32'(tc0), 32'h0);

        // up wrap
        cycle(1, 16'h9998, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 1);

        // down borrow and down wrap
        cycle(1, 16'h1000, 0, 0);
        cycle(0, 16'h0, 1, 0);
        chk("borrow", 32'(count0), 32'h0999);
        cycle(1, 16'h0000, 0, 0);
        cycle(0, 16'h0, 1, 0);
        chk("down_wrap_tc", 32'(tc0), 32'h1);
        cycle(0, 16'h0, 1, 0);

        // load of a wrap-condition value together with en
        cycle(1, 16'h9999, 1, 1);
        chk("load_wrap_tc", 32'(tc0), 32'h0);

        // scan over a full rotation at 0x1234
        cycle(1, 16'h1234, 0, 1);
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) cycle(0, 16'h0, 0, 1);

        // asynchronous reset mid-operation
        do_reset();

        // en held low at 0x0042
        cycle(1, 16'h0042, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 16'h0, 0, $urandom_range(0, 1));

        // reset landing on a tc pulse
        cycle(1, 16'h9999, 0, 1);
        cycle(0, 16'h0, 1, 1);
        chk("tc_before_rst", 32'(tc0), 32'h1);
        do_reset();

        // randomized traffic, biased toward wrap values
        for (int i = 0; i < 400; i++) begin
            logic        ld;
            logic [15:0] d;
            ld = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       d = 16'h9999;
                1:       d = 16'h0000;
                default: d = 16'($urandom);
            endcase
            cycle(ld, d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
